fd_cail_mult: RTL and testbench

Parametrised frequency-domain calibration stage between the forward-FFT output stream and the IFFT input stream. Each FFT bin of each frame is multiplied by a per-bin complex coefficient held in an internal coefficient RAM. The result is rounded, optionally saturated, and delivered through an AXI-Stream output FIFO with full backpressure. It replaces the fixed-width, non-backpressured calibration multiply with a block that is sized by parameters and adds frame-position tracking, a per-frame bypass and tlast error detection.

---
 rtl/fd_cail_mult.sv | 203 ++++++++++++++++++++
 tb/tb_fd_cail_mult.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_cail_mult.sv
// fd_cail_mult: per-bin complex calibration multiply between FFT output and IFFT input streams.
// Latency: a beat accepted in cycle N is written to the output FIFO at the end of N+3 and is visible at N+4.
// Backpressure: the 3-stage pipeline never stalls; s_tready drops once FIFO entries plus in-flight beats reach FIFO_DEPTH.
//
// Ports: SYS_CLK/SYS_RSTN clock and async active-low reset; cail_en selects calibrate vs passthrough
// (sampled on bin 0); cail_init_flag/cail_init_en/cail_init_data load the coefficient RAM
// ({imag, real} per word); s_t* is the AXI-Stream input and m_t* the AXI-Stream output;
// coef_loaded flags a complete coefficient set; err_tlast pulses on a tlast/bin-count mismatch.
// Build option: define FD_CAIL_SAT_EN to clamp results to DW bits; undefined, results wrap.
module fd_cail_mult #(
    parameter int DW         = 24,
    parameter int CW         = 16,
    parameter int COEF_FRAC  = 14,
    parameter int LOG2_NFFT  = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            SYS_CLK,
    input  logic            SYS_RSTN,
    input  logic            cail_en,
    input  logic            cail_init_flag,
    input  logic            cail_init_en,
    input  logic [31:0]     cail_init_data,
    input  logic [2*DW-1:0] s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic [2*DW-1:0] m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic            coef_loaded,
    output logic            err_tlast
);
    localparam int MW = DW + CW;
    localparam int PW = DW + CW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LOG2_NFFT-1:0] LAST_BIN = '1;
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
`ifdef FD_CAIL_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    // Full-precision signed product; operands are sign-extended to the product width first.
    function automatic logic signed [MW-1:0] cmul(input logic [DW-1:0] a, input logic [CW-1:0] b);
        logic signed [MW-1:0] ae;
        logic signed [MW-1:0] be;
        ae = {{CW{a[DW-1]}}, a};
        be = {{DW{b[CW-1]}}, b};
        return ae * be;
    endfunction

    // Round half up, drop the coefficient fraction, then clamp or wrap to DW bits.
    function automatic logic [DW-1:0] rnd_reduce(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        logic                 ovf;
        r   = (v + RND) >>> COEF_FRAC;
        ovf = (r[PW-1:DW-1] != {(PW-DW+1){r[PW-1]}});
        if (SAT_ON && ovf)
            return r[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return r[DW-1:0];
    endfunction

    // ---------------- coefficient load ----------------
    logic                 loading;
    logic [LOG2_NFFT-1:0] waddr;
    logic                 ram_we;
    logic [2*CW-1:0]      ram [2**LOG2_NFFT];

    // A flag in the same cycle as a write strobe restarts the load; the strobe is dropped.
    assign ram_we = loading && cail_init_en && !cail_init_flag;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            loading     <= 1'b0;
            waddr       <= '0;
            coef_loaded <= 1'b0;
        end else if (cail_init_flag) begin
            loading     <= 1'b1;
            waddr       <= '0;
            coef_loaded <= 1'b0;
        end else if (ram_we) begin
            waddr <= waddr + 1'b1;
            if (waddr == LAST_BIN) begin
                loading     <= 1'b0;
                coef_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (ram_we)
            ram[waddr] <= {cail_init_data[16 +: CW], cail_init_data[0 +: CW]};
    end

    // ---------------- input handshake and frame tracking ----------------
    logic                 rst_done;
    logic                 accept;
    logic [LOG2_NFFT-1:0] bin;
    logic                 frame_cal;
    logic                 cal_now;
    logic                 v1, v2, v3;
    logic [AW:0]          fcnt;
    logic [AW+1:0]        occ;

    // Count every beat already committed to reach the FIFO so it can never overflow.
    assign occ      = (AW+2)'(fcnt) + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3);
    assign s_tready = rst_done && !loading && (occ < (AW+2)'(FIFO_DEPTH));
    assign accept   = s_tvalid && s_tready;
    // Mode is decided on bin 0 and held for the rest of the frame.
    assign cal_now  = (bin == '0) ? (cail_en && coef_loaded) : frame_cal;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            rst_done  <= 1'b0;
            bin       <= '0;
            frame_cal <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            rst_done  <= 1'b1;
            err_tlast <= accept && (s_tlast != (bin == LAST_BIN));
            if (accept)
                frame_cal <= cal_now;
            if (cail_init_flag)
                bin <= '0;
            else if (accept)
                bin <= (s_tlast || bin == LAST_BIN) ? '0 : bin + 1'b1;
        end
    end

    // ---------------- pipeline ----------------
    logic [2*CW-1:0]        c1;
    logic [2*DW-1:0]        x1, x2, d3;
    logic                   last1, last2, last3, cal1, cal2;
    logic signed [MW-1:0]   p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0]   sum_i, sum_q;

    // Synchronous RAM read lines up with the registered input beat in S1.
    always_ff @(posedge SYS_CLK) begin
        c1 <= ram[bin];
    end

    assign sum_i = $signed({p_rr[MW-1], p_rr}) - $signed({p_ii[MW-1], p_ii});
    assign sum_q = $signed({p_ri[MW-1], p_ri}) + $signed({p_ir[MW-1], p_ir});

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            last1 <= 1'b0; last2 <= 1'b0; last3 <= 1'b0;
            cal1 <= 1'b0; cal2 <= 1'b0;
            x1 <= '0; x2 <= '0; d3 <= '0;
            p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
        end else begin
            // S1: register the beat
            v1    <= accept;
            last1 <= s_tlast;
            cal1  <= cal_now;
            x1    <= s_tdata;
            // S2: four products; raw data rides alongside for passthrough
            v2    <= v1;
            last2 <= last1;
            cal2  <= cal1;
            x2    <= x1;
            p_rr  <= cmul(x1[2*DW-1:DW], c1[CW-1:0]);
            p_ii  <= cmul(x1[DW-1:0],    c1[2*CW-1:CW]);
            p_ri  <= cmul(x1[2*DW-1:DW], c1[2*CW-1:CW]);
            p_ir  <= cmul(x1[DW-1:0],    c1[CW-1:0]);
            // S3: combine, round, reduce
            v3    <= v2;
            last3 <= last2;
            d3    <= cal2 ? {rnd_reduce(sum_i), rnd_reduce(sum_q)} : x2;
        end
    end

    // ---------------- output FIFO (first-word-fall-through) ----------------
    logic [2*DW:0] fmem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          pop;

    assign m_tvalid = (fcnt != '0);
    assign pop      = m_tvalid && m_tready;
    assign {m_tlast, m_tdata} = m_tvalid ? fmem[rp] : '0;

    always_ff @(posedge SYS_CLK) begin
        if (v3)
            fmem[wp] <= {last3, d3};
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (v3)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            fcnt <= fcnt + (AW+1)'(v3) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fd_cail_mult.sv
module tb_fd_cail_mult;
    localparam int DW = 24, CW = 16, COEF_FRAC = 14, LOG2_NFFT = 10, FIFO_DEPTH = 8;
    localparam int NBIN = 1 << LOG2_NFFT;

    logic          clk, rstn;
    logic          cail_en, cail_init_flag, cail_init_en;
    logic [31:0]   cail_init_data;
    logic [47:0]   s_tdata, m_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic          coef_loaded, err_tlast;

    fd_cail_mult #(.DW(DW), .CW(CW), .COEF_FRAC(COEF_FRAC), .LOG2_NFFT(LOG2_NFFT),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .SYS_CLK(clk), .SYS_RSTN(rstn), .cail_en(cail_en),
        .cail_init_flag(cail_init_flag), .cail_init_en(cail_init_en),
        .cail_init_data(cail_init_data),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .coef_loaded(coef_loaded), .err_tlast(err_tlast));

    int total = 0, bad = 0;
    int cyc = 0;
    int acc_total = 0;
    int first_acc_cyc = -1, first_out_cyc = -1;
    bit lat_arm = 0;
    bit tog_done = 0;

    // reference model state
    int          m_bin = 0;
    bit          m_mode = 0, m_loaded = 0;
    logic [31:0] m_coef [NBIN];
    logic [31:0] tb_coef [NBIN];
    logic [48:0] exp_q [$];
    int          err_q [$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx24(input logic [23:0] v);
        return longint'($signed(v));
    endfunction
    function automatic longint sx16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // value * coef / 2^14 with floor(x + 0.5), then clamp or keep low 24 bits
    function automatic logic [23:0] fit(input longint p);
        longint      r;
        logic [63:0] u;
        r = (p + 8192) >>> 14;
`ifdef FD_CAIL_SAT_EN
        if (r > 8388607)  r = 8388607;
        if (r < -8388608) r = -8388608;
`endif
        u = r;
        return u[23:0];
    endfunction

    function automatic logic [47:0] model_out(input logic [47:0] x, input logic [31:0] c, input bit cal);
        longint xi, xq, cr, ci;
        if (!cal) return x;
        xi = sx24(x[47:24]); xq = sx24(x[23:0]);
        cr = sx16(c[15:0]);  ci = sx16(c[31:16]);
        return {fit(xi * cr - xq * ci), fit(xi * ci + xq * cr)};
    endfunction

    // Called at the negedge before the posedge that accepts the beat.
    task automatic model_accept(input logic [47:0] d, input bit last);
        if (m_bin == 0) m_mode = cail_en && m_loaded;
        exp_q.push_back({last, model_out(d, m_coef[m_bin], m_mode)});
        if (last != (m_bin == NBIN - 1)) err_q.push_back(cyc + 1);
        m_bin = (last || m_bin == NBIN - 1) ? 0 : m_bin + 1;
        acc_total++;
        if (lat_arm && first_acc_cyc < 0) first_acc_cyc = cyc;
    endtask

    task automatic send(input logic [47:0] d, input bit last, input bit en);
        int w = 0;
        @(negedge clk);
        s_tvalid = 1; s_tdata = d; s_tlast = last; cail_en = en;
        while (!s_tready && w < 300) begin @(negedge clk); w++; end
        if (!s_tready) begin
            total++; bad++;
            $display("FAIL send_timeout: s_tready still %0d after %0d cycles", s_tready, w);
        end else begin
            model_accept(d, last);
        end
    endtask

    // kind 0: random data, 1: constant (1000,-500), 2: random with directed bins 5/6/7
    task automatic send_frame(input int len, input bit last_at_end, input int kind,
                              input bit en, input bit en_tog);
        for (int b = 0; b < len; b++) begin
            logic [47:0] d;
            bit          e;
            d = {24'($urandom), 24'($urandom)};
            if (kind == 1) d = {24'(1000), 24'(-500)};
            if (kind == 2) begin
                if (b == 5) d = {24'(3), 24'(4)};
                if (b == 6) d = {24'(3), 24'(0)};
                if (b == 7) d = {24'(8388607), 24'(0)};
            end
            e = en_tog ? bit'($urandom_range(0, 1)) : en;
            send(d, last_at_end && (b == len - 1), e);
        end
        @(negedge clk);
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic load(input int n, input bit chk);
        @(negedge clk); cail_init_flag = 1;
        @(negedge clk); cail_init_flag = 0;
        m_loaded = 0; m_bin = 0;
        for (int i = 0; i < n; i++) begin
            cail_init_en = 1; cail_init_data = tb_coef[i]; m_coef[i] = tb_coef[i];
            @(negedge clk);
            if (i == NBIN - 1) m_loaded = 1;
            if (chk) begin
                check("ready_low_while_loading", s_tready, 0);
                check("coef_loaded_low_while_loading", coef_loaded, 0);
            end
        end
        cail_init_en = 0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && w < 500) begin @(negedge clk); w++; end
        repeat (6) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("err_pulses_all_seen", err_q.size(), 0);
    endtask

    // output monitor / scoreboard
    always @(negedge clk) begin
        if (lat_arm && m_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", {m_tlast, m_tdata});
            end else begin
                logic [48:0] e;
                e = exp_q.pop_front();
                total++;
                if ({m_tlast, m_tdata} !== e) begin
                    bad++;
                    $display("FAIL out_beat: got last=%0d data=%h expected last=%0d data=%h",
                             m_tlast, m_tdata, e[48], e[47:0]);
                end
            end
        end
        if (err_tlast) begin
            if (err_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_err_tlast: pulse at cycle %0d", cyc);
            end else begin
                check("err_tlast_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        #600us;
        total++; bad++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int mark;
        rstn = 0; cail_en = 0; cail_init_flag = 0; cail_init_en = 0; cail_init_data = '0;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 1;
        for (int i = 0; i < NBIN; i++) tb_coef[i] = {16'd0, 16'd16384};

        repeat (3) @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_coef_loaded", coef_loaded, 0);
        check("rst_err_tlast", err_tlast, 0);
        rstn = 1;
        @(negedge clk);
        check("ready_after_release", s_tready, 1);

        // no coefficients yet: passthrough even with cail_en=1
        send_frame(NBIN, 1, 0, 1, 0);
        drain();

        // unity coefficients, constant frame, first-beat latency
        load(NBIN, 0);
        @(negedge clk);
        check("coef_loaded_after_load", coef_loaded, 1);
        lat_arm = 1; first_acc_cyc = -1; first_out_cyc = -1;
        send_frame(NBIN, 1, 1, 1, 0);
        drain();
        check("first_beat_latency", first_out_cyc - first_acc_cyc, 4);
        lat_arm = 0;

        // random coefficients with directed bins: j, 0.5, near-2.0
        for (int i = 0; i < NBIN; i++) tb_coef[i] = $urandom;
        tb_coef[5] = {16'd16384, 16'd0};
        tb_coef[6] = {16'd0, 16'd8192};
        tb_coef[7] = {16'd0, 16'd32767};
        load(NBIN, 0);
        @(negedge clk);
        check("coef_loaded_after_reload", coef_loaded, 1);

        // random downstream ready and cail_en toggling mid-frame
        tog_done = 0;
        fork
            begin send_frame(NBIN, 1, 2, 1, 1); tog_done = 1; end
            begin
                while (!tog_done) begin @(posedge clk); #1 m_tready = ($urandom_range(0, 3) != 0); end
                m_tready = 1;
            end
        join
        drain();

        // hard stall of 20 cycles mid-frame
        fork
            send_frame(NBIN, 1, 2, 1, 0);
            begin
                repeat (100) @(posedge clk);
                #1 m_tready = 0; mark = acc_total;
                repeat (20) @(posedge clk);
                @(negedge clk);
                check("ready_low_during_stall", s_tready, 0);
                total++;
                if (acc_total - mark > FIFO_DEPTH) begin
                    bad++;
                    $display("FAIL stall_accepts: got %0d beats accepted, limit %0d", acc_total - mark, FIFO_DEPTH);
                end
                @(posedge clk); #1 m_tready = 1;
            end
        join
        drain();

        // cail_en=0 frame is passthrough
        send_frame(NBIN, 1, 0, 0, 0);
        // early tlast at bin 100, missing tlast at bin 1023, early tlast at bin 3
        send_frame(101, 1, 0, 1, 0);
        send_frame(NBIN, 0, 2, 1, 0);
        send_frame(4, 1, 0, 1, 0);
        drain();

        // load restarted mid-frame and left partial, then a full reload
        send_frame(300, 0, 0, 1, 0);
        drain();
        load(10, 1);
        check("partial_coef_loaded", coef_loaded, 0);
        check("partial_s_tready", s_tready, 0);
        load(NBIN, 0);
        @(negedge clk);
        check("reload_s_tready", s_tready, 1);
        check("reload_coef_loaded", coef_loaded, 1);
        send_frame(NBIN, 1, 2, 1, 0);
        drain();

        // reset mid-frame discards in-flight beats; next frame has no coefficients
        send_frame(200, 0, 0, 1, 0);
        @(posedge clk); #2 rstn = 0;
        exp_q.delete(); err_q.delete();
        m_bin = 0; m_loaded = 0; m_mode = 0;
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_coef_loaded", coef_loaded, 0);
        check("midrst_s_tready", s_tready, 0);
        repeat (2) @(negedge clk);
        rstn = 1;
        send_frame(NBIN, 1, 2, 1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
